// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles every non-clock/reset signal of the load/store unit.
//   slave  : the unit itself (consumes requests, drives memory strobes).
//   master : the core + data memory side (issues requests, returns mem_rdata).
//   Request : req_valid/req_ready handshake, req_write, req_funct3, req_addr, req_wdata.
//   Response: resp_valid pulse, resp_rdata, resp_fault.
//   Memory  : mem_read/mem_write strobes, mem_addr (word aligned), mem_wdata, mem_rdata.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_fault;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Turns one core load/store request at a time into word-aligned accesses
//   to a word-only data memory. Sub-word stores are read-modify-write over
//   two memory cycles; loads return sign/zero-extended data; misaligned or
//   illegal-funct3 requests complete with resp_fault and touch no memory.
//   Ports: clk, rst (synchronous, active high), bus (load_store_unit_if.slave).
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RMW  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_fault_q, resp_fault_d;
  logic [31:0]           old_word_q, old_word_d;
  logic [ADDR_WIDTH-3:0] word_addr_q, word_addr_d;
  logic [1:0]            lane_q, lane_d;
  logic                  half_q, half_d;
  logic [15:0]           st_data_q, st_data_d;

  logic                  illegal, misaligned;
  logic [31:0]           lane_data, load_ext, merged;
  logic                  mem_read_c, mem_write_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [31:0]           mem_wdata_c;

  // Request decode. funct3[1:0] is the access size for every legal encoding.
  always_comb begin
    illegal    = bus.req_write ? (bus.req_funct3 > 3'd2)
                               : (bus.req_funct3 == 3'd3 || bus.req_funct3 == 3'd6 ||
                                  bus.req_funct3 == 3'd7);
    misaligned = (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) ||
                 (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'd0);
    lane_data  = bus.mem_rdata >> {bus.req_addr[1:0], 3'b000};
    case (bus.req_funct3)
      3'd0:    load_ext = {{24{lane_data[7]}}, lane_data[7:0]};
      3'd1:    load_ext = {{16{lane_data[15]}}, lane_data[15:0]};
      3'd4:    load_ext = {24'd0, lane_data[7:0]};
      3'd5:    load_ext = {16'd0, lane_data[15:0]};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  // Little-endian lane merge for the RMW write: a half store replaces the
  // byte pair selected by lane bit 1, a byte store replaces one lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      localparam logic [1:0] LANE = gi[1:0];
      logic       hit;
      logic [7:0] src;
      assign hit = half_q ? (LANE[1] == lane_q[1]) : (LANE == lane_q);
      assign src = half_q ? st_data_q[8*(gi%2) +: 8] : st_data_q[7:0];
      assign merged[8*gi +: 8] = hit ? src : old_word_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    old_word_d   = old_word_q;
    word_addr_d  = word_addr_q;
    lane_d       = lane_q;
    half_d       = half_q;
    st_data_d    = st_data_q;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          resp_rdata_d = '0;
          resp_fault_d = 1'b0;
          state_d      = S_RESP;
          if (illegal || misaligned) begin
            resp_fault_d = 1'b1;
          end else if (!bus.req_write) begin
            mem_read_c   = 1'b1;
            mem_addr_c   = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            resp_rdata_d = load_ext;
          end else if (bus.req_funct3[1:0] == 2'd2) begin
            mem_write_c  = 1'b1;
            mem_addr_c   = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_c  = bus.req_wdata;
          end else begin
            mem_read_c   = 1'b1;
            mem_addr_c   = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            old_word_d   = bus.mem_rdata;
            word_addr_d  = bus.req_addr[ADDR_WIDTH-1:2];
            lane_d       = bus.req_addr[1:0];
            half_d       = bus.req_funct3[0];
            st_data_d    = bus.req_wdata[15:0];
            state_d      = S_RMW;
          end
        end
      end
      S_RMW: begin
        mem_write_c = 1'b1;
        mem_addr_c  = {word_addr_q, 2'b00};
        mem_wdata_c = merged;
        state_d     = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset kills strobes immediately so an in-flight RMW write never lands.
    if (rst) begin
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
      old_word_q   <= '0;
      word_addr_q  <= '0;
      lane_q       <= '0;
      half_q       <= 1'b0;
      st_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      old_word_q   <= old_word_d;
      word_addr_q  <= word_addr_d;
      lane_q       <= lane_d;
      half_q       <= half_d;
      st_data_q    <= st_data_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.mem_read   = mem_read_c;
  assign bus.mem_write  = mem_write_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit with a small word memory model.
//   Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_load_store_unit;
  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  int   strobe_cnt;
  int   both_cnt;
  int   accept_cnt;
  logic [31:0] mem [0:63];

  logic        acc_rd, acc_wr, nxt_rd, nxt_wr;
  logic [31:0] acc_wdata, nxt_wdata;

  load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    if (bus.mem_read || bus.mem_write) strobe_cnt++;
    if (bus.mem_read && bus.mem_write) both_cnt++;
    if (!rst && bus.req_valid && bus.req_ready) accept_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: accept, then wait (bounded) for resp_valid.
  task automatic txn(input string tag, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_fault, input int exp_lat,
                     input logic check_quiet);
    int lat;
    int s0;
    s0 = strobe_cnt;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    #1;
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    acc_rd = bus.mem_read; acc_wr = bus.mem_write; acc_wdata = bus.mem_wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    nxt_rd = bus.mem_read; nxt_wr = bus.mem_write; nxt_wdata = bus.mem_wdata;
    lat = 1;
    while (!bus.resp_valid && lat < 6) begin
      @(negedge clk); #1; lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, bus.resp_rdata, exp_rd);
    chk({tag, ".fault"}, 32'(bus.resp_fault), 32'(exp_fault));
    if (check_quiet) chk({tag, ".no_strobe"}, 32'(strobe_cnt - s0), 32'd0);
  endtask

  logic        b_wr [0:5];
  logic [2:0]  b_f3 [0:5];
  logic [31:0] b_ad [0:5];
  logic [31:0] b_wd [0:5];
  logic [31:0] b_ex [0:5];

  initial begin
    int a0;
    int w;
    int lat;
    compared = 0; mismatched = 0; strobe_cnt = 0; both_cnt = 0; accept_cnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h10; bus.req_wdata = 32'd0;

    // Reset with a request pending: ignored, no strobes.
    repeat (3) @(negedge clk);
    #1;
    chk("rst.mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst.mem_write", 32'(bus.mem_write), 32'd0);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("reset.req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset.resp_rdata", bus.resp_rdata, 32'd0);
    chk("reset.resp_fault", 32'(bus.resp_fault), 32'd0);
    chk("reset.mem_addr", bus.mem_addr, 32'd0);
    chk("reset.mem_wdata", bus.mem_wdata, 32'd0);

    // Word store then loads of every width.
    txn("sw10", 1'b1, 3'd2, 32'h10, 32'h8899AABB, 32'h0, 1'b0, 1, 1'b0);
    chk("sw10.acc_write", 32'(acc_wr), 32'd1);
    chk("sw10.acc_wdata", acc_wdata, 32'h8899AABB);
    txn("lb13",  1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 1, 1'b0);
    chk("lb13.acc_read", 32'(acc_rd), 32'd1);
    txn("lbu13", 1'b0, 3'd4, 32'h13, 32'h0, 32'h00000088, 1'b0, 1, 1'b0);
    txn("lh12",  1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 1, 1'b0);
    txn("lw10",  1'b0, 3'd2, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 1, 1'b0);
    txn("lhu10", 1'b0, 3'd5, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 1, 1'b0);
    txn("lb11",  1'b0, 3'd0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 1, 1'b0);
    txn("lbu10", 1'b0, 3'd4, 32'h10, 32'h0, 32'h000000BB, 1'b0, 1, 1'b0);

    // SB read-modify-write.
    txn("sw20", 1'b1, 3'd2, 32'h20, 32'h11223344, 32'h0, 1'b0, 1, 1'b0);
    txn("sb21", 1'b1, 3'd0, 32'h21, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0);
    chk("sb21.acc_read", 32'(acc_rd), 32'd1);
    chk("sb21.acc_write", 32'(acc_wr), 32'd0);
    chk("sb21.rmw_write", 32'(nxt_wr), 32'd1);
    chk("sb21.rmw_read", 32'(nxt_rd), 32'd0);
    chk("sb21.rmw_wdata", nxt_wdata, 32'h1122EF44);
    txn("lw20a", 1'b0, 3'd2, 32'h20, 32'h0, 32'h1122EF44, 1'b0, 1, 1'b0);

    // SH read-modify-write onto the upper half.
    txn("sw20b", 1'b1, 3'd2, 32'h20, 32'h11223344, 32'h0, 1'b0, 1, 1'b0);
    txn("sh22", 1'b1, 3'd1, 32'h22, 32'h0000CAFE, 32'h0, 1'b0, 2, 1'b0);
    chk("sh22.rmw_wdata", nxt_wdata, 32'hCAFE3344);
    txn("lw20b", 1'b0, 3'd2, 32'h20, 32'h0, 32'hCAFE3344, 1'b0, 1, 1'b0);

    // Faults: no memory strobe, rdata cleared.
    txn("f_lw21",  1'b0, 3'd2, 32'h21, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    txn("f_sh23",  1'b1, 3'd1, 32'h23, 32'h1234, 32'h0, 1'b1, 1, 1'b1);
    txn("f_lh01",  1'b0, 3'd1, 32'h01, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    txn("f_ld3",   1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    txn("f_st4",   1'b1, 3'd4, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    txn("ok_lw10", 1'b0, 3'd2, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 1, 1'b0);

    // Reset during the RMW cycle of an SB drops the write.
    txn("sw30", 1'b1, 3'd2, 32'h30, 32'h55667788, 32'h0, 1'b0, 1, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h30; bus.req_wdata = 32'h000000AA;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rmwrst.mem_write", 32'(bus.mem_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmwrst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rmwrst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rmwrst.mem_word", mem[12], 32'h55667788);
    txn("rmwrst.lw30", 1'b0, 3'd2, 32'h30, 32'h0, 32'h55667788, 1'b0, 1, 1'b0);

    // Back-to-back with req_valid held high: alternating SB / LW.
    b_wr[0]=1'b1; b_f3[0]=3'd0; b_ad[0]=32'h40; b_wd[0]=32'h11; b_ex[0]=32'h0;
    b_wr[1]=1'b0; b_f3[1]=3'd2; b_ad[1]=32'h40; b_wd[1]=32'h0;  b_ex[1]=32'h00000011;
    b_wr[2]=1'b1; b_f3[2]=3'd0; b_ad[2]=32'h41; b_wd[2]=32'h22; b_ex[2]=32'h0;
    b_wr[3]=1'b0; b_f3[3]=3'd2; b_ad[3]=32'h40; b_wd[3]=32'h0;  b_ex[3]=32'h00002211;
    b_wr[4]=1'b1; b_f3[4]=3'd0; b_ad[4]=32'h43; b_wd[4]=32'h33; b_ex[4]=32'h0;
    b_wr[5]=1'b0; b_f3[5]=3'd2; b_ad[5]=32'h40; b_wd[5]=32'h0;  b_ex[5]=32'h33002211;
    a0 = accept_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = b_wr[0]; bus.req_funct3 = b_f3[0];
    bus.req_addr = b_ad[0]; bus.req_wdata = b_wd[0];
    #1;
    for (int i = 0; i < 6; i++) begin
      w = 0;
      while (!bus.req_ready && w < 8) begin @(negedge clk); #1; w++; end
      chk($sformatf("b2b%0d.ready", i), 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      if (i < 5) begin
        bus.req_write = b_wr[i+1]; bus.req_funct3 = b_f3[i+1];
        bus.req_addr = b_ad[i+1]; bus.req_wdata = b_wd[i+1];
      end else begin
        bus.req_valid = 1'b0;
      end
      #1;
      lat = 1;
      while (!bus.resp_valid && lat < 6) begin
        chk($sformatf("b2b%0d.busy_ready", i), 32'(bus.req_ready), 32'd0);
        @(negedge clk); #1; lat++;
      end
      chk($sformatf("b2b%0d.resp_ready", i), 32'(bus.req_ready), 32'd0);
      chk($sformatf("b2b%0d.lat", i), 32'(lat), b_wr[i] ? 32'd2 : 32'd1);
      if (!b_wr[i]) chk($sformatf("b2b%0d.rdata", i), bus.resp_rdata, b_ex[i]);
      @(negedge clk); #1;
    end
    chk("b2b.accepts", 32'(accept_cnt - a0), 32'd6);
    chk("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's memory stage and the word-only data memory. Accepts one load/store request at a time and generates word-aligned memory accesses. Sub-word stores (SB/SH) are done as a read-modify-write over two memory cycles. Returns sign- or zero-extended load data and flags misaligned or illegal accesses as faults.

## Interface
Parameters:
- ADDR_WIDTH, 32: width of the byte address on both sides.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  core presents a request this cycle.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32 funct3 field.
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle pulse; the request has completed.
- resp_rdata  output  32  extended load data; 0 for stores and faults.
- resp_fault  output  1  qualifies resp_valid: misaligned or illegal funct3.
- mem_read  output  1  read strobe to data memory.
- mem_write  output  1  write strobe to data memory; memory writes at posedge.
- mem_addr  output  ADDR_WIDTH  word-aligned byte address, bits [1:0] always 0.
- mem_wdata  output  32  word to write.
- mem_rdata  input  32  combinational read data, valid in the same cycle as mem_read.

## Operation
- States: IDLE, RMW, RESP. Reset state is IDLE.
- IDLE:
  - req_ready=1.
  - Request accepted on any cycle with req_valid=1.
- Legality:
  - Fault on misalignment: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
  - Fault on illegal funct3: loads 3/6/7, stores 3-7.
  - On fault: no memory strobe; go to RESP with resp_fault=1 and resp_rdata=0.
- Load accept:
  - Same cycle: mem_read=1, mem_addr={req_addr[ADDR_WIDTH-1:2],2'b00}.
  - Select the lane: shift mem_rdata right by 8*addr[1:0].
  - Extend: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Register the result into resp_rdata, then go to RESP.
- SW accept: same cycle mem_write=1, mem_wdata=req_wdata; go to RESP.
- SB/SH accept:
  - Same cycle: mem_read=1.
  - Latch mem_rdata, the word address, lane offset, size and req_wdata; go to RMW.
- RMW:
  - req_ready=0, mem_write=1 at the latched address.
  - mem_wdata = old word with the target lanes replaced (little-endian).
    - SB: req_wdata[7:0] to lane addr[1:0].
    - SH: req_wdata[15:0] to lanes addr[1]*2 and +1.
  - Next state RESP.
- RESP:
  - resp_valid=1, req_ready=0.
  - resp_fault and resp_rdata hold the registered values.
  - Next state IDLE.
- Strobes:
  - mem_read and mem_write are never both 1.
  - Both are 0 outside the cycles listed above.
  - mem_addr/mem_wdata are don't-care when both strobes are 0; drive 0.
- Reset:
  - rst=1 forces both strobes to 0 combinationally, even mid-RMW, so an in-flight RMW write is dropped.
  - Next state IDLE; registered outputs cleared.

## Timing
- Reset values: req_ready=1 after reset; resp_valid=0, resp_rdata=0, resp_fault=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Latency from accept edge to the resp_valid cycle:
  - load, SW, fault: 1 cycle (2-cycle occupancy).
  - SB/SH: 2 cycles (3-cycle occupancy).
- Core holds req_* stable while req_valid=1 and req_ready=0. Requests presented during RMW/RESP are not accepted.
- req_valid during rst is ignored.
- Back-to-back: a new request is accepted in the cycle after RESP.
- RMW write lands at the posedge ending the RMW cycle, so a load accepted after RESP sees the merged word.

## Test plan
- After reset, write mem[0x10]=0x8899AABB with SW. Then LB at 0x13 gives resp_rdata=0xFFFFFF88; LBU at 0x13 gives 0x00000088; LH at 0x12 gives 0xFFFF8899; LW at 0x10 gives 0x8899AABB. Each resp_valid arrives 1 cycle after accept.
- With mem[0x20]=0x11223344, SB at 0x21 with wdata 0xDEADBEEF: mem_read in the accept cycle, mem_write in the next cycle with mem_wdata=0x1122EF44, resp_valid 2 cycles after accept. A following LW at 0x20 returns 0x1122EF44.
- SH at 0x22 with wdata 0x0000CAFE onto 0x11223344 writes 0xCAFE3344.
- Misalignment: LW at 0x21, SH at 0x23, LH at 0x01 each give resp_fault=1 and resp_rdata=0, with no strobe on mem_read or mem_write at any cycle.
- Illegal funct3: load funct3=3 and store funct3=4 each give resp_fault=1 with no memory access.
- Assert rst during the RMW cycle of an SB: mem_write stays 0, memory is unchanged, next cycle req_ready=1 and resp_valid=0.
- Hold req_valid high continuously with alternating SB/LW: req_ready=0 in RMW and RESP, each request is accepted exactly once, and mem_read and mem_write are never both 1.
